matmul_stream_core: RTL and testbench

MATMUL_STREAM_CORE -- requirements
Module: matmul_stream_core

---
 rtl/matmul_stream_core.sv | 144 ++++++++++++++
 tb/tb_matmul_stream_core.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_stream_core.sv
// Streaming N x N matrix multiplier: loads A then B row-major, runs one MAC per
// cycle over (i, j, k), then drains C row-major over a valid/ready result port.
module matmul_stream_core #(
  parameter int N      = 3,
  parameter int DW     = 8,
  parameter int SIGNED = 0,
  localparam int CW    = 2 * DW + $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [CW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          done,
  output logic [1:0]    state_o
);

  // Handshake: a beat moves on the rising edge where valid && ready are both 1;
  // ready never depends on valid, and the result port holds data while stalled.

  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] LAST = KW'(N - 1);

  typedef enum logic [1:0] {
    LOAD_A  = 2'd0,
    LOAD_B  = 2'd1,
    COMPUTE = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [KW-1:0] ld_r, ld_c;
  logic [KW-1:0] ci, cj, ck;
  logic [KW-1:0] od_r, od_c;
  logic [CW-1:0] acc;
  logic          done_q;

  logic [DW-1:0] a_mem [N][N];
  logic [DW-1:0] b_mem [N][N];
  logic [CW-1:0] c_mem [N][N];

  logic          in_fire, out_fire;
  logic          ld_last, mac_last, od_last;
  logic [CW-1:0] prod, mac_sum;

  function automatic logic [CW-1:0] ext(input logic [DW-1:0] v);
    if (SIGNED != 0) return {{(CW-DW){v[DW-1]}}, v};
    else             return {{(CW-DW){1'b0}}, v};
  endfunction

  function automatic logic [KW-1:0] inc(input logic [KW-1:0] v);
    return (v == LAST) ? '0 : v + 1'b1;
  endfunction

  assign in_ready  = (state == LOAD_A) || (state == LOAD_B);
  assign out_valid = (state == DRAIN);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign ld_last   = (ld_r == LAST) && (ld_c == LAST);
  assign mac_last  = (ci == LAST) && (cj == LAST) && (ck == LAST);
  assign od_last   = (od_r == LAST) && (od_c == LAST);

  // Extension to CW before multiplying keeps the truncated product exact in
  // two's complement, so one multiplier serves both signed and unsigned.
  assign prod     = ext(a_mem[ci][ck]) * ext(b_mem[ck][cj]);
  assign mac_sum  = acc + prod;

  // C is fully written before DRAIN, so gating keeps X out of idle cycles.
  assign out_data = out_valid ? c_mem[od_r][od_c] : '0;
  assign done     = done_q;
  assign state_o  = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD_A;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD_A:  if (in_fire && ld_last)   state_nxt = LOAD_B;
      LOAD_B:  if (in_fire && ld_last)   state_nxt = COMPUTE;
      COMPUTE: if (mac_last)             state_nxt = DRAIN;
      DRAIN:   if (out_fire && od_last)  state_nxt = LOAD_A;
      default:                           state_nxt = LOAD_A;
    endcase
    if (clr) state_nxt = LOAD_A;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_r   <= '0;
      ld_c   <= '0;
      ci     <= '0;
      cj     <= '0;
      ck     <= '0;
      od_r   <= '0;
      od_c   <= '0;
      acc    <= '0;
      done_q <= 1'b0;
    end else if (clr) begin
      ld_r   <= '0;
      ld_c   <= '0;
      ci     <= '0;
      cj     <= '0;
      ck     <= '0;
      od_r   <= '0;
      od_c   <= '0;
      acc    <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= out_fire && od_last;
      if (in_fire) begin
        ld_c <= inc(ld_c);
        if (ld_c == LAST) ld_r <= inc(ld_r);
      end
      if (state == COMPUTE) begin
        ck  <= inc(ck);
        acc <= (ck == LAST) ? '0 : mac_sum;
        if (ck == LAST) begin
          cj <= inc(cj);
          if (cj == LAST) ci <= inc(ci);
        end
      end
      if (out_fire) begin
        od_c <= inc(od_c);
        if (od_c == LAST) od_r <= inc(od_r);
      end
    end
  end

  // Operand and result storage carries no reset.
  always_ff @(posedge clk) begin
    if (!clr && in_fire && state == LOAD_A) a_mem[ld_r][ld_c] <= in_data;
    if (!clr && in_fire && state == LOAD_B) b_mem[ld_r][ld_c] <= in_data;
    if (!clr && state == COMPUTE && ck == LAST) c_mem[ci][cj] <= mac_sum;
  end

endmodule

// File: tb/tb_matmul_stream_core.sv
// Directed bench for matmul_stream_core: one unsigned and one signed instance,
// hand-computed result matrices, stall, clear and back-to-back scenarios.
module tb_matmul_stream_core;

  logic        clk;
  logic        rst_n;
  logic        clr       [2];
  logic [7:0]  in_data   [2];
  logic        in_valid  [2];
  logic        in_ready  [2];
  logic [17:0] out_data  [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic        done      [2];
  logic [1:0]  state_o   [2];

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt [2] = '{0, 0};
  logic [31:0] exp_q[$];

  matmul_stream_core #(.N(3), .DW(8), .SIGNED(0)) dut_u (
    .clk(clk), .rst_n(rst_n), .clr(clr[0]),
    .in_data(in_data[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .out_data(out_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .done(done[0]), .state_o(state_o[0])
  );

  matmul_stream_core #(.N(3), .DW(8), .SIGNED(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .clr(clr[1]),
    .in_data(in_data[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .out_data(out_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .done(done[1]), .state_o(state_o[1])
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done[0]) done_cnt[0]++;
    if (done[1]) done_cnt[1]++;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic push_exp(input int c[9]);
    for (int e = 0; e < 9; e++) exp_q.push_back(32'(c[e]));
  endtask

  // driver: presents A then B, returns the number of cycles spent
  task automatic load_mats(input int d, input logic [7:0] a[9], input logic [7:0] b[9],
                           output int cyc);
    int w;
    cyc = 0;
    for (int e = 0; e < 18; e++) begin
      @(negedge clk);
      in_data[d]  = (e < 9) ? a[e] : b[e-9];
      in_valid[d] = 1'b1;
      cyc++;
      w = 0;
      while (!in_ready[d] && w < 300) begin
        @(negedge clk);
        cyc++;
        w++;
      end
      if (!in_ready[d]) begin
        check_eq("load_timeout", 32'(in_ready[d]), 32'd1);
        in_valid[d] = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    in_valid[d] = 1'b0;
  endtask

  // sink + scoreboard: waits through COMPUTE, then takes 9 results
  task automatic collect(input int d, input bit rnd, output int wait_cyc);
    int got, budget;
    logic stalled;
    logic [17:0] held;
    wait_cyc = 0;
    got = 0;
    budget = 0;
    stalled = 1'b0;
    held = '0;
    @(negedge clk);
    while (!out_valid[d] && budget < 100) begin
      check_eq("in_ready_compute", 32'(in_ready[d]), 32'd0);
      wait_cyc++;
      budget++;
      @(negedge clk);
    end
    if (!out_valid[d]) begin
      check_eq("out_valid_timeout", 32'(out_valid[d]), 32'd1);
      return;
    end
    while (got < 9 && budget < 300) begin
      if (stalled) check_eq("stall_stable", 32'(out_data[d]), 32'(held));
      check_eq("in_ready_drain", 32'(in_ready[d]), 32'd0);
      check_eq("out_valid_drain", 32'(out_valid[d]), 32'd1);
      out_ready[d] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_ready[d]) begin
        if (exp_q.size() > 0) check_eq("result", 32'(out_data[d]), exp_q.pop_front());
        got++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        held = out_data[d];
      end
      budget++;
      @(negedge clk);
    end
    out_ready[d] = 1'b0;
    check_eq("transfer_count", 32'(got), 32'd9);
    check_eq("done_pulse", 32'(done[d]), 32'd1);
    check_eq("state_after_drain", 32'(state_o[d]), 32'd0);
    check_eq("out_valid_after_drain", 32'(out_valid[d]), 32'd0);
    @(negedge clk);
    check_eq("done_one_cycle", 32'(done[d]), 32'd0);
  endtask

  logic [7:0] m_id[9], m_seq[9], m_rev[9], m_255[9], m_80[9], m_ff[9], m_one[9], m_two[9];
  int c_seq[9], c_255[9], c_s80[9], c_sm3[9], c_ab[9], c_two[9], c_rev[9];

  initial begin
    int lc, wc, base;
    m_id  = '{8'd1, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd1};
    m_two = '{8'd2, 8'd0, 8'd0, 8'd0, 8'd2, 8'd0, 8'd0, 8'd0, 8'd2};
    m_seq = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
    m_rev = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    for (int e = 0; e < 9; e++) begin
      m_255[e] = 8'hFF;
      m_80[e]  = 8'h80;
      m_ff[e]  = 8'hFF;
      m_one[e] = 8'h01;
      c_255[e] = 195075;
      c_s80[e] = 49152;
      c_sm3[e] = 32'h3FFFD;
    end
    c_seq = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    c_two = '{2, 4, 6, 8, 10, 12, 14, 16, 18};
    c_ab  = '{30, 24, 18, 84, 69, 54, 138, 114, 90};
    c_rev = '{90, 114, 138, 54, 69, 84, 18, 24, 30};

    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      clr[d] = 1'b0; in_data[d] = '0; in_valid[d] = 1'b0; out_ready[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check_eq("rst_state", 32'(state_o[d]), 32'd0);
      check_eq("rst_in_ready", 32'(in_ready[d]), 32'd1);
      check_eq("rst_out_valid", 32'(out_valid[d]), 32'd0);
      check_eq("rst_done", 32'(done[d]), 32'd0);
    end
    rst_n = 1'b1;

    // identity x 1..9, no stalls, latency 18 load + 27 compute
    push_exp(c_seq);
    load_mats(0, m_id, m_seq, lc);
    collect(0, 1'b0, wc);
    check_eq("load_cycles", 32'(lc), 32'd18);
    check_eq("first_out_latency", 32'(lc + wc), 32'd45);

    // unsigned full scale
    push_exp(c_255);
    load_mats(0, m_255, m_255, lc);
    collect(0, 1'b0, wc);

    // signed corner cases
    push_exp(c_s80);
    load_mats(1, m_80, m_80, lc);
    collect(1, 1'b0, wc);
    push_exp(c_sm3);
    load_mats(1, m_ff, m_one, lc);
    collect(1, 1'b0, wc);

    // random sink stalls
    push_exp(c_ab);
    load_mats(0, m_seq, m_rev, lc);
    collect(0, 1'b1, wc);

    // clear mid-compute, then a fresh run
    load_mats(0, m_seq, m_rev, lc);
    repeat (10) @(negedge clk);
    clr[0] = 1'b1;
    @(negedge clk);
    clr[0] = 1'b0;
    check_eq("clr_state", 32'(state_o[0]), 32'd0);
    check_eq("clr_in_ready", 32'(in_ready[0]), 32'd1);
    check_eq("clr_out_valid", 32'(out_valid[0]), 32'd0);
    base = done_cnt[0];
    repeat (40) @(negedge clk);
    check_eq("clr_no_done", 32'(done_cnt[0]), 32'(base));
    check_eq("clr_idle_state", 32'(state_o[0]), 32'd0);
    push_exp(c_two);
    load_mats(0, m_two, m_seq, lc);
    collect(0, 1'b0, wc);

    // back-to-back runs with in_valid held high
    push_exp(c_seq);
    push_exp(c_rev);
    load_mats(0, m_seq, m_id, lc);
    fork
      collect(0, 1'b0, wc);
      load_mats(0, m_rev, m_seq, lc);
    join
    collect(0, 1'b1, wc);

    // asynchronous reset mid-compute, then resume
    load_mats(0, m_seq, m_rev, lc);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst_state", 32'(state_o[0]), 32'd0);
    check_eq("async_rst_in_ready", 32'(in_ready[0]), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    push_exp(c_seq);
    load_mats(0, m_id, m_seq, lc);
    collect(0, 1'b0, wc);

    check_eq("done_total_u", 32'(done_cnt[0]), 32'd7);
    check_eq("done_total_s", 32'(done_cnt[1]), 32'd2);
    check_eq("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
